// File: rtl/choice_result_tx.sv
// rtl/choice_result_tx.sv - serial UART-style transmitter for one choice result vector
`timescale 1ns/1ps
module choice_result_tx #(
   parameter int         CLKS_PER_BIT = 16,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] p,
   input  logic [4:0] q,
   input  logic [6:0] r,
   input  logic [3:0] s,
   input  logic [5:0] t,
   input  logic [4:0] u,
   input  logic [4:0] v,
   input  logic [5:0] w,
   input  logic [4:0] x,
   input  logic       y,
   input  logic       z,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [2:0]       byte_q, byte_d;
   logic [63:0]      pkt_q, pkt_d;
   logic             done_q, done_d;
   logic             bit_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         pkt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         pkt_q   <= pkt_d;
         done_q  <= done_d;
      end
   end

   assign bit_tick = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      pkt_d   = pkt_q;
      done_d  = 1'b0;
      div_d   = (state_q == S_IDLE || bit_tick) ? '0 : div_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Sync byte sits in the low byte so {byte,bit} indexes the whole packet.
               pkt_d   = {6'b0, z, y, x, w, v, u, t, s, r, q, p, SYNC_BYTE};
               bit_d   = '0;
               byte_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_tick) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               byte_d = byte_q + 3'd1;
               if (byte_q == 3'd7) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_START;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Decoded straight from state so an asynchronous reset forces the line high at once.
   always_comb begin
      tx = 1'b1;
      case (state_q)
         S_START: tx = 1'b0;
         S_DATA:  tx = pkt_q[{byte_q, bit_q}];
         default: tx = 1'b1;
      endcase
   end

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_choice_result_tx.sv
// tb/tb_choice_result_tx.sv - directed bench with byte scoreboard for choice_result_tx
`timescale 1ns/1ps
module tb_choice_result_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, va, vb;
   logic [4:0] p, q, u, v, x;
   logic [6:0] r;
   logic [3:0] s;
   logic [5:0] t, w;
   logic       y, z;
   logic       rdy_a, busy_a, tx_a, done_a;
   logic       rdy_b, busy_b, tx_b, done_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   bit         rx_act[2];
   int         rx_cnt[2];
   logic [7:0] rx_sh[2];

   choice_result_tx #(.CLKS_PER_BIT(16), .SYNC_BYTE(8'hA5)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a),
      .p(p), .q(q), .r(r), .s(s), .t(t), .u(u), .v(v), .w(w), .x(x), .y(y), .z(z),
      .tx(tx_a), .busy(busy_a), .done(done_a));

   choice_result_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b),
      .p(p), .q(q), .r(r), .s(s), .t(t), .u(u), .v(v), .w(w), .x(x), .y(y), .z(z),
      .tx(tx_b), .busy(busy_b), .done(done_b));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART receiver: cnt 0 is the first start-bit cycle, samples taken mid-bit.
   task automatic rx_tick(input int ch, input logic txv, input int cpb);
      logic [7:0] e;
      if (!rx_act[ch]) begin
         if (txv === 1'b0) begin
            rx_act[ch] = 1'b1;
            rx_cnt[ch] = 0;
         end
      end else begin
         rx_cnt[ch]++;
         if (rx_cnt[ch] == cpb / 2) begin
            check(ch ? "rx_b_start" : "rx_a_start", txv, 1'b0);
         end else if (rx_cnt[ch] > cpb && rx_cnt[ch] < 9 * cpb && rx_cnt[ch] % cpb == cpb / 2) begin
            rx_sh[ch] = {txv, rx_sh[ch][7:1]};
         end else if (rx_cnt[ch] == 9 * cpb + cpb / 2) begin
            check(ch ? "rx_b_stop" : "rx_a_stop", txv, 1'b1);
            rx_act[ch] = 1'b0;
            if (ch == 0) begin
               if (exp_a.size() == 0) check("rx_a_unexpected_byte", exp_a.size(), 1);
               else begin
                  e = exp_a.pop_front();
                  check("rx_a_byte", rx_sh[ch], e);
               end
            end else begin
               if (exp_b.size() == 0) check("rx_b_unexpected_byte", exp_b.size(), 1);
               else begin
                  e = exp_b.pop_front();
                  check("rx_b_byte", rx_sh[ch], e);
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_act[0] = 1'b0;
         rx_act[1] = 1'b0;
      end else begin
         rx_tick(0, tx_a, 16);
         rx_tick(1, tx_b, 2);
      end
   end

   task automatic set_vec(input logic [4:0] pp, input logic [4:0] qq, input logic [6:0] rr,
                          input logic [3:0] ss, input logic [5:0] tt, input logic [4:0] uu,
                          input logic [4:0] vv, input logic [5:0] ww, input logic [4:0] xx,
                          input logic yy, input logic zz);
      p = pp; q = qq; r = rr; s = ss; t = tt; u = uu; v = vv; w = ww; x = xx; y = yy; z = zz;
   endtask

   // Called just after a negedge; returns at the negedge following the accept edge.
   task automatic accept(input int ch, input logic [63:0] pkt, input bit hold);
      check(ch ? "b_ready_before" : "a_ready_before", ch ? rdy_b : rdy_a, 1'b1);
      if (ch == 0) va = 1'b1; else vb = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (ch == 0) exp_a.push_back(pkt[8*i +: 8]);
         else         exp_b.push_back(pkt[8*i +: 8]);
      end
      @(negedge clk);
      acc_cyc = cyc;
      if (!hold) begin
         if (ch == 0) va = 1'b0; else vb = 1'b0;
      end
      check(ch ? "b_tx_start" : "a_tx_start", ch ? tx_b : tx_a, 1'b0);
      check(ch ? "b_ready_low" : "a_ready_low", ch ? rdy_b : rdy_a, 1'b0);
      check(ch ? "b_busy_high" : "a_busy_high", ch ? busy_b : busy_a, 1'b1);
   endtask

   task automatic wait_done(input int ch, input int exp_lat);
      int guard = 0;
      while ((ch ? done_b : done_a) !== 1'b1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check(ch ? "b_done_latency" : "a_done_latency", cyc - acc_cyc + 1, exp_lat);
      check(ch ? "b_done_tx" : "a_done_tx", ch ? tx_b : tx_a, 1'b1);
      check(ch ? "b_done_ready" : "a_done_ready", ch ? rdy_b : rdy_a, 1'b1);
      check(ch ? "b_done_busy" : "a_done_busy", ch ? busy_b : busy_a, 1'b0);
   endtask

   task automatic done_ends(input int ch);
      @(negedge clk);
      check(ch ? "b_done_width" : "a_done_width", ch ? done_b : done_a, 1'b0);
   endtask

   initial begin
      int tx_low;
      rst_n = 1'b0;
      va = 1'b0;
      vb = 1'b0;
      set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_tx", tx_a, 1'b1);
      check("rst_ready", rdy_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Vector 1
      set_vec(5'b00001, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      accept(0, 64'h0000_0000_0000_21A5, 1'b0);
      wait_done(0, 1281);
      done_ends(0);

      // Vector 2, all ones
      set_vec(5'h1F, 5'h1F, 7'h7F, 4'hF, 6'h3F, 5'h1F, 5'h1F, 6'h3F, 5'h1F, 1'b1, 1'b1);
      accept(0, 64'h03FF_FFFF_FFFF_FFA5, 1'b0);
      wait_done(0, 1281);
      done_ends(0);

      // Busy protection
      set_vec(5'b00001, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      accept(0, 64'h0000_0000_0000_21A5, 1'b1);
      p = 5'b11011;
      repeat (600) @(negedge clk);
      check("busy_ready_low", rdy_a, 1'b0);
      va = 1'b0;
      wait_done(0, 1281);
      done_ends(0);
      tx_low = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || rdy_a !== 1'b1) tx_low++;
      end
      check("busy_no_second_packet", tx_low, 0);

      // Reset mid-frame
      set_vec(5'b00001, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      accept(0, 64'h0000_0000_0000_21A5, 1'b0);
      repeat (399) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx", tx_a, 1'b1);
      check("midrst_busy", busy_a, 1'b0);
      check("midrst_ready", rdy_a, 1'b1);
      check("midrst_done", done_a, 1'b0);
      check("midrst_bytes_sent", exp_a.size(), 6);
      exp_a.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tx_low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_a !== 1'b0 || tx_a !== 1'b1) tx_low++;
      end
      check("postrst_quiet", tx_low, 0);
      set_vec(5'h1F, 5'h1F, 7'h7F, 4'hF, 6'h3F, 5'h1F, 5'h1F, 6'h3F, 5'h1F, 1'b1, 1'b1);
      accept(0, 64'h03FF_FFFF_FFFF_FFA5, 1'b0);
      wait_done(0, 1281);
      done_ends(0);

      // Back-to-back: in_valid high across both vectors, one idle cycle between
      set_vec(5'b01101, 5'b01001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      accept(0, 64'h0000_0000_0001_2DA5, 1'b1);
      set_vec(5'b10011, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      wait_done(0, 1281);
      accept(0, 64'h0000_0000_0000_33A5, 1'b0);
      wait_done(0, 1281);
      done_ends(0);

      // CLKS_PER_BIT = 2 instance, vector 2
      set_vec(5'h1F, 5'h1F, 7'h7F, 4'hF, 6'h3F, 5'h1F, 5'h1F, 6'h3F, 5'h1F, 1'b1, 1'b1);
      accept(1, 64'h03FF_FFFF_FFFF_FFA5, 1'b0);
      wait_done(1, 161);
      done_ends(1);

      repeat (10) @(negedge clk);
      check("a_queue_drained", exp_a.size(), 0);
      check("b_queue_drained", exp_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/choice_result_tx.md
# choice_result_tx

Serial transmitter that carries one result vector of the `choice` arithmetic/logic unit off-chip or to a logging receiver. It accepts the operand pair (P, Q) together with all `choice` outputs (R..Z) over a valid/ready handshake and latches them. It then sends them as a fixed 8-byte UART-style frame: a sync byte followed by the packed vector. It sits downstream of `choice` and is the response side of the stimulus path that drives P/Q into it.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..1024.
- SYNC_BYTE, 8'hA5, first byte of every packet.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  result vector present on data inputs.
- in_ready  out  1  block idle and able to accept.
- p, q  in  5 each  operands applied to `choice`.
- r  in  7; s  in  4; t, w  in  6 each; u, v, x  in  5 each; y, z  in  1 each  `choice` outputs.
- tx  out  1  serial line, idle high.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Packed word, 56 bits: [4:0]=p, [9:5]=q, [16:10]=r, [20:17]=s, [26:21]=t, [31:27]=u, [36:32]=v, [42:37]=w, [47:43]=x, [48]=y, [49]=z, [55:50]=0.
- Packet: byte0 = SYNC_BYTE, then bytes1..7 = word[7:0], word[15:8], …, word[55:48].
- Each byte is a 10-bit frame: start bit (0), 8 data bits LSB first, stop bit (1). Frames follow back-to-back with no idle gap.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch all inputs and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = current bit, 8 bits, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 7, increment it and go to START; otherwise go to IDLE and pulse done.
- Inputs are sampled only at acceptance. Later input changes and in_valid while busy are ignored; nothing is queued.
- Reset values: tx=1, in_ready=1, busy=0, done=0, state IDLE, bit/byte/divider counters 0.
- Reset asserted mid-packet: tx returns high asynchronously and the packet is abandoned. No done pulse. After release the block is in IDLE.

## Timing
- Acceptance at edge k: in_ready=0, busy=1, tx=0 from edge k+1 (1-cycle latency).
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Packet length: 80×CLKS_PER_BIT cycles; 1280 at the default.
- At edge k+1+80×CLKS_PER_BIT: tx=1, busy=0, in_ready=1, done=1 for exactly one cycle.
- Back-to-back: in_valid high during the done cycle is accepted at the next edge. Minimum gap between packets is 1 idle cycle of tx=1.
- The divider counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1. The bit counter wraps 7→0 and the byte counter 7→0.

## Test plan
- Vector 1, reset then p=5'b00001, q=5'b00001, all results 0, one-cycle in_valid: decoded bytes A5,21,00,00,00,00,00,00. done occurs exactly 1281 cycles after the accept edge.
- Vector 2, all inputs all-ones (p=q=5'b11111, r=7'h7F, …, y=z=1): bytes A5,FF,FF,FF,FF,FF,FF,03. Bits 50–55 are transmitted as 0.
- Busy protection: accept vector 1, then hold in_valid=1 with p=5'b11011 for 600 cycles. The packet still decodes as in vector 1, and no second packet starts until after done.
- Reset mid-frame: assert rst_n=0 at cycle 400 of a packet. tx=1, busy=0 and in_ready=1 within the same cycle, with no done pulse. A new vector after release transmits correctly.
- Back-to-back: in_valid held high across two vectors (p=01101/q=01001, then p=10011/q=00001). There is exactly one tx=1 idle cycle between packets. Both decode correctly, giving word byte0 of 0x2D, then 0x33.
- CLKS_PER_BIT=2: vector 2 repeated. Every bit lasts 2 cycles and done occurs 161 cycles after accept.
